sram_arbiter: RTL and testbench

- Two-requester arbiter/sequencer for the shared single-port 16x16 `sram`.
- Port 0 is the CPU memory port; port 1 is the program loader / I/O DMA port.
- Accepts request/grant transactions and drives the SRAM's `we_n`, `addr` and `data_in`.
- Captures `data_out` for reads and returns it to the winning requester with a valid pulse.

---
 rtl/mano_mem_pkg.sv | 21 ++
 rtl/sram_arb_pick.sv | 68 ++++++
 rtl/sram_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_mem_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   MANO_AW / MANO_DW : default address / data widths of the 16x16 sram
//   arb_state_e       : sequencer states (IDLE, ACCESS, RWAIT)
//   port_id_e         : requester id (PORT0 = CPU, PORT1 = loader/DMA)
package mano_mem_pkg;

    localparam int unsigned MANO_AW = 16;
    localparam int unsigned MANO_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Winner select for the two-port SRAM arbiter.
// Build option: SRAM_ARB_RR_EN
//   defined   -> round-robin; a 1-bit priority pointer moves to the loser
//                after every grant (reset value PORT0)
//   undefined -> fixed priority, port 0 always wins; no pointer state
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (pointer only)
//   m0_req     : port 0 request
//   m1_req     : port 1 request
//   take       : the arbiter is issuing the current winner this cycle
//   win_id     : winning port (meaningful when win_vld = 1)
//   win_vld    : at least one request is pending
module sram_arb_pick
    import mano_mem_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     m0_req,
    input  logic     m1_req,
    input  logic     take,
    output port_id_e win_id,
    output logic     win_vld
);

    assign win_vld = m0_req | m1_req;

`ifdef SRAM_ARB_RR_EN
    port_id_e ptr_q;
    port_id_e ptr_d;

    // The pointer names the port that wins a tie.
    always_comb begin
        win_id = PORT0;
        if (m0_req && m1_req) begin
            win_id = ptr_q;
        end else if (m1_req) begin
            win_id = PORT1;
        end
    end

    // After a grant, hand tie priority to the port that did not win.
    always_comb begin
        ptr_d = ptr_q;
        if (take) begin
            ptr_d = (win_id == PORT0) ? PORT1 : PORT0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst_n, take};

    always_comb begin
        win_id = PORT0;
        if (m1_req && !m0_req) begin
            win_id = PORT1;
        end
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter/sequencer for the shared single-port sram.
// Port 0 is the CPU memory port, port 1 the program loader / I/O DMA port.
// Sequence per access: IDLE (latch winner) -> ACCESS (gnt, sram samples)
// -> IDLE for writes, or -> RWAIT (capture data_out) -> IDLE with rvalid.
// Build option: SRAM_ARB_RR_EN selects round-robin arbitration (see
// sram_arb_pick); default is fixed priority with port 0 winning.
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   mN_req/we/addr/wdata      : request from port N (held until mN_gnt)
//   mN_gnt                    : 1-cycle pulse, port N access issued
//   mN_rvalid / mN_rdata      : 1-cycle read-valid pulse / held read data
//   sram_we_n/addr/data_in    : registered drive to the sram
//   sram_data_out             : sram read data, valid 1 cycle after addr
module sram_arbiter
    import mano_mem_pkg::*;
#(
    parameter int unsigned AW = MANO_AW,
    parameter int unsigned DW = MANO_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          sram_we_n,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_data_in,
    input  logic [DW-1:0] sram_data_out
);

    arb_state_e    state_q,   state_d;
    port_id_e      winner_q,  winner_d;
    logic          we_n_q,    we_n_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic          gnt0_q,    gnt0_d;
    logic          gnt1_q,    gnt1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q,  rdata0_d;
    logic [DW-1:0] rdata1_q,  rdata1_d;

    port_id_e pick_id;
    logic     pick_vld;
    logic     take;

    // Requests only matter in IDLE; the pick result is ignored elsewhere.
    assign take = (state_q == IDLE) && pick_vld;

    sram_arb_pick u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0_req  (m0_req),
        .m1_req  (m1_req),
        .take    (take),
        .win_id  (pick_id),
        .win_vld (pick_vld)
    );

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        we_n_d    = 1'b1;       // write strobe only ever lasts the ACCESS cycle
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        case (state_q)
            IDLE: begin
                if (take) begin
                    winner_d = pick_id;
                    state_d  = ACCESS;
                    if (pick_id == PORT0) begin
                        we_n_d  = ~m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        gnt0_d  = 1'b1;
                    end else begin
                        we_n_d  = ~m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        gnt1_d  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // we_n still high here means the access is a read.
                state_d = we_n_q ? RWAIT : IDLE;
            end
            RWAIT: begin
                state_d = IDLE;
                if (winner_q == PORT0) begin
                    rdata0_d  = sram_data_out;
                    rvalid0_d = 1'b1;
                end else begin
                    rdata1_d  = sram_data_out;
                    rvalid1_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            winner_q  <= PORT0;
            we_n_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            we_n_q    <= we_n_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign m0_gnt       = gnt0_q;
    assign m1_gnt       = gnt1_q;
    assign m0_rvalid    = rvalid0_q;
    assign m1_rvalid    = rvalid1_q;
    assign m0_rdata     = rdata0_q;
    assign m1_rdata     = rdata1_q;
    assign sram_we_n    = we_n_q;
    assign sram_addr    = addr_q;
    assign sram_data_in = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed requester stimulus, a behavioural
// 16x16 sram, and a negedge monitor that checks grants and read returns
// against queues filled by the stimulus.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic        sram_we_n;
    logic [15:0] sram_addr, sram_data_in, sram_data_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          gq[$];
    logic [15:0] rq0[$];
    logic [15:0] rq1[$];
    int          last_rv0 = 0;
    int          last_rv1 = 0;
    logic        prev_we_n = 1'b1;

    logic [15:0] mem [16];
    logic        mem_clr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter #(.AW(16), .DW(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req        (m0_req),
        .m0_we         (m0_we),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_gnt        (m0_gnt),
        .m0_rvalid     (m0_rvalid),
        .m0_rdata      (m0_rdata),
        .m1_req        (m1_req),
        .m1_we         (m1_we),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_gnt        (m1_gnt),
        .m1_rvalid     (m1_rvalid),
        .m1_rdata      (m1_rdata),
        .sram_we_n     (sram_we_n),
        .sram_addr     (sram_addr),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    // Behavioural sram: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 2) ? 16'h000C : 16'h0000;
            sram_data_out <= 16'h0000;
        end else begin
            if (!sram_we_n) mem[sram_addr[3:0]] <= sram_data_in;
            sram_data_out <= mem[sram_addr[3:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: grant order, read data, write-strobe shape.
    always @(negedge clk) begin
        int          exp_id;
        logic [15:0] exp_d;
        if (m0_gnt || m1_gnt) begin
            if (m0_gnt && m1_gnt) chk("single_gnt", 32'd1, 32'd0);
            else if (gq.size() == 0) chk("unexpected_gnt", {31'd0, m1_gnt}, 32'hFFFF_FFFF);
            else begin
                exp_id = gq.pop_front();
                chk("gnt_order", {31'd0, m1_gnt}, exp_id);
            end
        end
        if (m0_rvalid) begin
            last_rv0 <= cyc;
            if (rq0.size() == 0) chk("unexpected_m0_rvalid", {16'd0, m0_rdata}, 32'hFFFF_FFFF);
            else begin
                exp_d = rq0.pop_front();
                chk("m0_rdata", {16'd0, m0_rdata}, {16'd0, exp_d});
            end
        end
        if (m1_rvalid) begin
            last_rv1 <= cyc;
            if (rq1.size() == 0) chk("unexpected_m1_rvalid", {16'd0, m1_rdata}, 32'hFFFF_FFFF);
            else begin
                exp_d = rq1.pop_front();
                chk("m1_rdata", {16'd0, m1_rdata}, {16'd0, exp_d});
            end
        end
        if (!sram_we_n) chk("we_n_low_shape", {31'd0, (m0_gnt | m1_gnt) & prev_we_n}, 32'd1);
        prev_we_n <= sram_we_n;
    end

    // Present a transaction on port p and wait for its grant (called at negedge).
    task automatic do_txn(input int p, input logic we, input logic [15:0] a,
                          input logic [15:0] d, output int gcyc);
        bit ok = 1'b0;
        if (p == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((p == 0) ? m0_gnt : m1_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        gcyc = cyc;
        chk((p == 0) ? "m0_gnt_timeout" : "m1_gnt_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic idle_port(input int p);
        if (p == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int issue, g0, g1, g2, g3, g4, g5, ga, gb;

        rst_n = 1'b0; mem_clr = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h0001; m0_wdata = 16'h00FF;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0000; m1_wdata = 16'h0000;

        // Reset held 3 cycles with a pending write request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
            chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
            chk("rst_rdata", {m0_rdata, m1_rdata}, 32'd0);
        end
        m0_req = 1'b0; mem_clr = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // Single write then read on port 0.
        gq.push_back(0);
        issue = cyc;
        do_txn(0, 1'b1, 16'h0001, 16'h0005, g0);
        idle_port(0);
        chk("wr_gnt_latency", g0 - issue, 32'd1);
        chk("wr_we_n_in_access", {31'd0, sram_we_n}, 32'd0);
        @(negedge clk);
        chk("wr_we_n_after", {31'd0, sram_we_n}, 32'd1);

        gq.push_back(0); rq0.push_back(16'h0005);
        issue = cyc;
        do_txn(0, 1'b0, 16'h0001, 16'h0000, g0);
        idle_port(0);
        chk("rd_gnt_latency", g0 - issue, 32'd1);
        repeat (4) @(negedge clk);
        chk("rd_rvalid_latency", last_rv0 - issue, 32'd3);

        // Simultaneous reads of 0x0002 from a fresh pointer: port 0 first.
        apply_reset();
        gq.push_back(0); gq.push_back(1);
        rq0.push_back(16'h000C); rq1.push_back(16'h000C);
        fork
            begin do_txn(0, 1'b0, 16'h0002, 16'h0000, ga); idle_port(0); end
            begin do_txn(1, 1'b0, 16'h0002, 16'h0000, gb); idle_port(1); end
        join
        repeat (5) @(negedge clk);
        chk("contention_gnt_gap", gb - ga, 32'd3);
        chk("contention_rvalid_gap", last_rv1 - last_rv0, 32'd3);

        // Continuous contention: p0 four writes to 0x4, p1 two writes to 0x5.
        apply_reset();
`ifdef SRAM_ARB_RR_EN
        gq.push_back(0); gq.push_back(1); gq.push_back(0);
        gq.push_back(1); gq.push_back(0); gq.push_back(0);
`else
        gq.push_back(0); gq.push_back(0); gq.push_back(0);
        gq.push_back(0); gq.push_back(1); gq.push_back(1);
`endif
        fork
            begin
                for (int i = 0; i < 4; i++) do_txn(0, 1'b1, 16'h0004, 16'h0A00 + 16'(i), ga);
                idle_port(0);
            end
            begin
                for (int i = 0; i < 2; i++) do_txn(1, 1'b1, 16'h0005, 16'h0B00 + 16'(i), gb);
                idle_port(1);
            end
        join
        @(negedge clk);
        gq.push_back(1); gq.push_back(1);
        rq1.push_back(16'h0A03); rq1.push_back(16'h0B01);
        do_txn(1, 1'b0, 16'h0004, 16'h0000, ga);
        do_txn(1, 1'b0, 16'h0005, 16'h0000, gb);
        idle_port(1);
        repeat (4) @(negedge clk);

        // Back-to-back on port 1: three writes then three reads.
        for (int i = 0; i < 6; i++) gq.push_back(1);
        rq1.push_back(16'h0000); rq1.push_back(16'h0005); rq1.push_back(16'h000C);
        do_txn(1, 1'b1, 16'h0000, 16'h0000, g0);
        do_txn(1, 1'b1, 16'h0001, 16'h0005, g1);
        do_txn(1, 1'b1, 16'h0002, 16'h000C, g2);
        do_txn(1, 1'b0, 16'h0000, 16'h0000, g3);
        do_txn(1, 1'b0, 16'h0001, 16'h0000, g4);
        do_txn(1, 1'b0, 16'h0002, 16'h0000, g5);
        idle_port(1);
        chk("b2b_wr_gap1", g1 - g0, 32'd2);
        chk("b2b_wr_gap2", g2 - g1, 32'd2);
        chk("b2b_wr_to_rd", g3 - g2, 32'd2);
        chk("b2b_rd_gap1", g4 - g3, 32'd3);
        chk("b2b_rd_gap2", g5 - g4, 32'd3);
        repeat (4) @(negedge clk);

        // Make m0_rdata non-zero, then reset during RWAIT of the next read.
        gq.push_back(0); rq0.push_back(16'h000C);
        do_txn(0, 1'b0, 16'h0002, 16'h0000, g0);
        idle_port(0);
        repeat (3) @(negedge clk);
        chk("pre_abort_m0_rdata", {16'd0, m0_rdata}, 32'h0000_000C);

        gq.push_back(0);
        do_txn(0, 1'b0, 16'h0001, 16'h0000, g0);
        idle_port(0);
        @(negedge clk);             // RWAIT
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("abort_m0_rdata", {16'd0, m0_rdata}, 32'd0);
        chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_late_rvalid", {31'd0, m0_rvalid}, 32'd0);

        // Arbiter is idle straight after reset: next request granted in 1 cycle.
        gq.push_back(0); rq0.push_back(16'h0005);
        issue = cyc;
        do_txn(0, 1'b0, 16'h0001, 16'h0000, g0);
        idle_port(0);
        chk("post_reset_gnt_latency", g0 - issue, 32'd1);
        repeat (5) @(negedge clk);

        chk("gnt_queue_drained", gq.size(), 32'd0);
        chk("rq0_drained", rq0.size(), 32'd0);
        chk("rq1_drained", rq1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
